// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : RV32I memory stage. Byte-addressable little-endian RAM with
//             byte/half/word loads (two cycles, one stall) and stores (one
//             cycle). Misaligned or undefined accesses are suppressed and
//             flagged on err.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int D_WIDTH = 32,   // data/address width (RV32I: 32)
  parameter int A_WIDTH = 17    // decoded low address bits, RAM = 2^A_WIDTH bytes
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] wdata,
  output logic [D_WIDTH-1:0] rdata,
  output logic               stall,
  output logic               err
);

  localparam int DEPTH = 2 ** (A_WIDTH - 2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [D_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [D_WIDTH-1:0] word_q;
  logic [1:0]         off_q;
  logic [2:0]         f3_q;

  logic [A_WIDTH-3:0] w_idx;
  logic               w_misaligned;
  logic               w_load_ok;
  logic               w_store_ok;
  logic               w_store_go;
  logic               w_load_go;
  logic [3:0]         w_be;
  logic [D_WIDTH-1:0] w_wlanes;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;

  // Upper address bits alias onto the decoded window and are deliberately dropped.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^addr[D_WIDTH-1:A_WIDTH];

  assign w_idx = addr[A_WIDTH-1:2];

  // funct3[1:0] encodes size (00 B, 01 H, 10 W); alignment follows from it.
  assign w_misaligned = ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
                        ((funct3[1:0] == 2'b01) && addr[0]);
  assign w_load_ok    = !w_misaligned &&
                        (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_store_ok   = !w_misaligned && (funct3 inside {3'b000, 3'b001, 3'b010});

  // Replicate the store data so each lane already holds the right bytes;
  // the byte enables then pick which lanes actually commit.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_be             = 4'b0001 << addr[1:0];
        w_wlanes         = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be             = addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes         = {2{wdata[15:0]}};
      end
      default: w_be      = 4'b1111;
    endcase
  end

  // Next-state and handshake outputs; stores take priority, reset overrides all.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    err        = 1'b0;
    w_store_go = 1'b0;
    w_load_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memwrite) begin
          if (w_store_ok) w_store_go = 1'b1;
          else            err        = 1'b1;
        end else if (memread) begin
          if (w_load_ok) begin
            w_load_go = 1'b1;
            stall     = 1'b1;
            state_d   = RESP;
          end else begin
            err = 1'b1;
          end
        end
      end
      // Inputs seen here are the held copy of the load just issued.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d    = IDLE;
      stall      = 1'b0;
      err        = 1'b0;
      w_store_go = 1'b0;
      w_load_go  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // RAM byte-lane writes and synchronous load capture (RAM is never reset).
  always_ff @(posedge clk) begin
    if (w_store_go) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) mem_q[w_idx][l*8 +: 8] <= w_wlanes[l*8 +: 8];
      end
    end
    if (w_load_go) begin
      word_q <= mem_q[w_idx];
      off_q  <= addr[1:0];
      f3_q   <= funct3;
    end
  end

  assign w_byte = word_q[{off_q, 3'b000} +: 8];
  assign w_half = off_q[1] ? word_q[31:16] : word_q[15:0];

  // Lane select and sign/zero extension; result is only driven in RESP.
  always_comb begin
    rdata = '0;
    if ((state_q == RESP) && !rst) begin
      case (f3_q)
        3'b000:  rdata = {{24{w_byte[7]}}, w_byte};
        3'b001:  rdata = {{16{w_half[15]}}, w_half};
        3'b100:  rdata = {24'h0, w_byte};
        3'b101:  rdata = {16'h0, w_half};
        default: rdata = word_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU. Consumes the ALU result as a byte address and the second register operand as store data.
- Performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) against an internal byte-addressable, little-endian RAM.
- Loads take two cycles. During the first cycle a stall is raised so the core holds PC and pipeline inputs. Stores complete in one cycle.
- Misaligned or undefined accesses are suppressed and flagged.

Parameters:
- D_WIDTH, 32, data and address width.
- A_WIDTH, 17, number of low address bits decoded; RAM holds 2^A_WIDTH bytes.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- memread  input  1  load request.
- memwrite  input  1  store request.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  D_WIDTH  byte address (ALU output).
- wdata  input  D_WIDTH  store data (register operand 2).
- rdata  output  D_WIDTH  extended load result, valid only in RESP.
- stall  output  1  core must hold all inputs stable and not advance.
- err  output  1  access suppressed (misaligned or illegal funct3).

Behaviour:
- Reset:
  - state = IDLE; stall = 0; err = 0; rdata = 0.
  - RAM contents are not reset.
  - rst held on any edge overrides every request, including mid-load.
- FSM states: IDLE, RESP.
- Address decode:
  - Only addr[A_WIDTH-1:0] is used; upper bits are ignored, so addresses alias.
  - Word base is addr[A_WIDTH-1:2].
- Legality (combinational, evaluated in IDLE):
  - W requires addr[1:0]=00.
  - H/HU require addr[0]=0.
  - funct3 011, 110 and 111 are illegal for loads.
  - Stores accept only 000, 001 and 010.
  - Illegal access: err=1 that cycle, no RAM write, no stall, state stays IDLE.
- Priority: memwrite and memread asserted together is treated as a store; the load is ignored.
- Store (IDLE, legal):
  - Byte lanes written at the rising edge:
    - SB: lane addr[1:0] gets wdata[7:0].
    - SH: lanes addr[1]*2 and +1 get wdata[15:0].
    - SW: all four lanes.
  - stall=0; state stays IDLE. A store may issue in back-to-back cycles.
- Load:
  - IDLE, legal: stall=1 combinationally in the request cycle. The RAM word is read synchronously into a register at the edge, along with addr[1:0] and funct3. Next state is RESP.
  - RESP:
    - stall=0.
    - rdata = selected byte/half/word from the registered word.
    - B/H sign-extend; BU/HU zero-extend.
    - The core writes back at the end of this cycle. Next state is IDLE.
    - Requests presented in RESP are ignored, because they are the held copy of the same instruction.
- Outside RESP, rdata = 0.
- Load latency: request cycle plus one; exactly one stall cycle per legal load.
- A load that follows a store to the same address returns the newly stored data (store committed at prior edge).
- Reset during RESP: next cycle is IDLE, stall=0, rdata=0; the load result is discarded.
- No request (memread=memwrite=0): IDLE, all outputs 0.

Test Plan:
- SW wdata=0xDEADBEEF addr=0x100 -> stall=0. Then LW addr=0x100 -> stall=1 for one cycle, then rdata=0xDEADBEEF with stall=0.
- After the above: LB 0x103 -> rdata=0xFFFFFFDE. LBU 0x103 -> 0x000000DE. LB 0x100 -> 0xFFFFFFEF.
- SH wdata=0x12348001 addr=0x102, then LW 0x100 -> 0x8001BEEF. LH 0x102 -> 0xFFFF8001. LHU 0x102 -> 0x00008001.
- LW 0x101 -> err=1, stall=0, rdata=0. SW 0xFFFFFFFF at 0x102 -> err=1. Subsequent LW 0x100 -> still 0x8001BEEF.
- Aliasing: SW 0xCAFEF00D at 0x00020100 (A_WIDTH=17) -> LW 0x100 returns 0xCAFEF00D.
- Reset and priority:
  - LW issued, rst asserted in RESP cycle -> next cycle stall=0, rdata=0, state IDLE.
  - memread=memwrite=1 with SW 0x55 at 0x200 -> no stall, LW 0x200 returns 0x00000055.
